// File: rtl/ucode_loader_pkg.sv
// Shared definitions for the microcode loader: FSM encoding and stream framing constants.
package ucode_loader_pkg;

    localparam int HDR_BYTES = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_LO = 3'd1,
        ST_HDR_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_e;

    function automatic int bytes_per_word(input int word_width);
        return (word_width + 7) / 8;
    endfunction

endpackage

// File: rtl/ucode_loader_word_assembler.sv
// Little-endian byte-to-word assembly register with byte counter.
module word_assembler
    import ucode_loader_pkg::*;
#(
    parameter int WORD_WIDTH = 47
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  shift_i,
    input  logic [7:0]            byte_i,
    output logic [WORD_WIDTH-1:0] word_next_o,
    output logic                  last_byte_o
);

    localparam int BPW     = bytes_per_word(WORD_WIDTH);
    localparam int CW      = $clog2(BPW);
    localparam int HOLD_W  = 8 * (BPW - 1);

    // Only the earlier BPW-1 bytes need storage; the final byte is merged
    // combinationally so the full word is available on its transfer edge.
    logic [HOLD_W-1:0] asm_q, asm_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [8*BPW-1:0]  asm_next;

    assign asm_next    = {byte_i, asm_q};
    assign word_next_o = asm_next[WORD_WIDTH-1:0];
    assign last_byte_o = (cnt_q == CW'(BPW - 1));

    always_comb begin
        asm_d = asm_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (shift_i) begin
            asm_d = asm_next[8*BPW-1:8];
            cnt_d = last_byte_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            asm_q <= '0;
            cnt_q <= '0;
        end else begin
            asm_q <= asm_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ucode_loader.sv
// Streams microcode bytes into the writable control store and holds the
// sequencer in reset until a complete load has been written.
module ucode_loader
    import ucode_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int WORD_WIDTH = 47
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [WORD_WIDTH-1:0] wdata,
    output logic                  seq_hold,
    output logic                  done,
    output logic                  error,
    output state_e                dbg_state_o
);

    localparam int BYTES_PER_WORD = bytes_per_word(WORD_WIDTH);
    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

    // Handshake: a byte moves on any rising edge where in_valid && in_ready;
    // in_valid may drop at any time and in_ready depends only on state.
    state_e                state_q, state_d;
    logic [15:0]           count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic                  asm_shift, asm_clear, asm_last;
    logic [WORD_WIDTH-1:0] asm_word_next;
    logic                  xfer;
    logic [16:0]           hdr_count;
    logic                  last_word;

    word_assembler #(.WORD_WIDTH(WORD_WIDTH)) u_asm (
        .clock       (clock),
        .reset       (reset),
        .clear_i     (asm_clear),
        .shift_i     (asm_shift),
        .byte_i      (in_data),
        .word_next_o (asm_word_next),
        .last_byte_o (asm_last)
    );

    assign in_ready  = (state_q == ST_HDR_LO) || (state_q == ST_HDR_HI) || (state_q == ST_DATA);
    assign xfer      = in_valid && in_ready;
    assign hdr_count = {1'b0, in_data, count_q[7:0]};
    // 17-bit compare so a count equal to the full store depth ends cleanly.
    assign last_word = ((17'(addr_q) + 17'd1) == {1'b0, count_q});

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        addr_d    = addr_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        asm_shift = 1'b0;
        asm_clear = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) state_d = ST_HDR_LO;
            end
            ST_HDR_LO: begin
                if (xfer) begin
                    count_d[7:0] = in_data;
                    state_d      = ST_HDR_HI;
                end
            end
            ST_HDR_HI: begin
                if (xfer) begin
                    count_d[15:8] = in_data;
                    if (hdr_count == 17'd0) begin
                        state_d = ST_DONE;
                    end else if (hdr_count > DEPTH) begin
                        state_d = ST_ERROR;
                    end else begin
                        asm_clear = 1'b1;
                        addr_d    = '0;
                        state_d   = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    asm_shift = 1'b1;
                    if (asm_last) begin
                        waddr_d = addr_q;
                        wdata_d = asm_word_next;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (last_word) begin
                    state_d = ST_DONE;
                end else begin
                    addr_d    = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    asm_clear = 1'b1;
                    state_d   = ST_DATA;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            addr_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign we          = (state_q == ST_WRITE);
    assign waddr       = waddr_q;
    assign wdata       = wdata_q;
    assign seq_hold    = (state_q != ST_DONE);
    assign done        = (state_q == ST_DONE);
    assign error       = (state_q == ST_ERROR);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ucode_loader.sv
// Self-checking bench for ucode_loader: scoreboard of expected store writes.
module tb_ucode_loader;
    import ucode_loader_pkg::*;

    localparam int AW  = 13;
    localparam int WW  = 47;
    localparam int BPW = 6;

    logic          clock = 1'b0;
    logic          reset, start, in_valid;
    logic [7:0]    in_data;
    logic          in_ready, we, seq_hold, done, error;
    logic [AW-1:0] waddr;
    logic [WW-1:0] wdata;
    state_e        dbg_state;

    logic [AW+WW-1:0] exp_q[$];
    logic [AW+WW-1:0] exp_w;
    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int cyc    = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    ucode_loader #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .seq_hold    (seq_hold),
        .done        (done),
        .error       (error),
        .dbg_state_o (dbg_state)
    );

    // Write monitor: every we pulse must match the oldest expected write.
    always @(negedge clock) begin
        if (we === 1'b1) begin
            we_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_we: waddr=%0d wdata=%h, required no write", waddr, wdata);
            end else begin
                exp_w = exp_q.pop_front();
                if ({waddr, wdata} !== exp_w) begin
                    errors++;
                    $display("FAIL write: waddr=%0d wdata=%h, required waddr=%0d wdata=%h",
                             waddr, wdata, exp_w[AW+WW-1:WW], exp_w[WW-1:0]);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int g = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && g < 50) begin
            @(negedge clock);
            g++;
        end
        checks++;
        if (g >= 50) begin
            errors++;
            $display("FAIL ready_timeout: in_ready=%b after %0d cycles, required 1", in_ready, g);
        end
        @(negedge clock);
        in_valid = 1'b0;
        if (gap) @(negedge clock);
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [WW-1:0] w);
        exp_q.push_back({a, w});
    endtask

    task automatic test_reset();
        int bad = 0;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (seq_hold !== 1'b1 || in_ready !== 1'b0 || we !== 1'b0 || done !== 1'b0 ||
                error !== 1'b0 || waddr !== '0 || wdata !== '0 || dbg_state !== ST_IDLE) begin
                errors++; bad++;
                $display("FAIL reset_idle: hold=%b rdy=%b we=%b done=%b err=%b waddr=%0d wdata=%h, required 1 0 0 0 0 0 0",
                         seq_hold, in_ready, we, done, error, waddr, wdata);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_two_words(input bit gap);
        logic [47:0] wa = 48'h060504030201;
        logic [47:0] wb = 48'hFFFFFFFFFFFF;
        int base = we_cnt;
        int c0;
        int g = 0;
        pulse_start();
        push_exp(0, 47'h060504030201);
        push_exp(1, 47'h7FFFFFFFFFFF);
        c0 = cyc;
        send_byte(8'h02, gap);
        send_byte(8'h00, gap);
        for (int k = 0; k < BPW; k++) send_byte(wa[8*k +: 8], gap);
        for (int k = 0; k < BPW - 1; k++) send_byte(wb[8*k +: 8], gap);
        send_byte(wb[8*(BPW-1) +: 8], 1'b0);
        checks++;
        if (we !== 1'b1 || in_ready !== 1'b0 || waddr !== AW'(1)) begin
            errors++;
            $display("FAIL last_write_cycle: we=%b in_ready=%b waddr=%0d, required 1 0 1", we, in_ready, waddr);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b1 || seq_hold !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL load_done: done=%b seq_hold=%b error=%b, required 1 0 0", done, seq_hold, error);
        end
        if (!gap) begin
            checks++;
            if (cyc - c0 !== 2 + 2 * (BPW + 1)) begin
                errors++;
                $display("FAIL load_cycles: %0d, required %0d", cyc - c0, 2 + 2 * (BPW + 1));
            end
        end
        while (g < 3) begin @(negedge clock); g++; end
        checks++;
        if (we_cnt - base !== 2 || exp_q.size() !== 0 || done !== 1'b1) begin
            errors++;
            $display("FAIL write_count: writes=%0d pending=%0d done=%b, required 2 0 1", we_cnt - base, exp_q.size(), done);
        end
    endtask

    task automatic test_zero_count();
        int base = we_cnt;
        pulse_start();
        checks++;
        if (done !== 1'b0 || dbg_state !== ST_HDR_LO) begin
            errors++;
            $display("FAIL restart: done=%b state=%0d, required 0 %0d", done, dbg_state, ST_HDR_LO);
        end
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        checks++;
        if (done !== 1'b1 || seq_hold !== 1'b0) begin
            errors++;
            $display("FAIL zero_count_done: done=%b seq_hold=%b, required 1 0", done, seq_hold);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (we_cnt !== base) begin
            errors++;
            $display("FAIL zero_count_writes: %0d, required 0", we_cnt - base);
        end
    endtask

    task automatic test_error_then_recover();
        int base = we_cnt;
        int g = 0;
        logic [47:0] rb;
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h20, 1'b0);
        checks++;
        if (error !== 1'b1 || seq_hold !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL oversize_error: error=%b seq_hold=%b done=%b, required 1 1 0", error, seq_hold, done);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (error !== 1'b1 || we_cnt !== base || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL error_sticky: error=%b writes=%0d in_ready=%b, required 1 0 0", error, we_cnt - base, in_ready);
        end
        pulse_start();
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL error_clear: error=%b, required 0", error);
        end
        rb = {$urandom, $urandom};
        push_exp(0, rb[WW-1:0]);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int k = 0; k < BPW; k++) send_byte(rb[8*k +: 8], ($urandom_range(0, 1) == 1));
        while (done !== 1'b1 && g < 20) begin @(negedge clock); g++; end
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || seq_hold !== 1'b0 || we_cnt - base !== 1) begin
            errors++;
            $display("FAIL recover_load: done=%b error=%b seq_hold=%b writes=%0d, required 1 0 0 1",
                     done, error, seq_hold, we_cnt - base);
        end
    endtask

    task automatic test_full_depth_header();
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h20, 1'b0);
        checks++;
        if (dbg_state !== ST_DATA || error !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_depth_accept: state=%0d error=%b in_ready=%b, required %0d 0 1",
                     dbg_state, error, in_ready, ST_DATA);
        end
        apply_reset();
    endtask

    task automatic test_reset_abort();
        int base = we_cnt;
        logic [47:0] rb;
        rb = {$urandom, $urandom};
        pulse_start();
        push_exp(0, rb[WW-1:0]);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int k = 0; k < BPW; k++) send_byte(rb[8*k +: 8], 1'b0);
        send_byte(8'h11, 1'b0);
        pulse_start();
        checks++;
        if (dbg_state !== ST_DATA || in_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored: state=%0d in_ready=%b done=%b, required %0d 1 0",
                     dbg_state, in_ready, done, ST_DATA);
        end
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (dbg_state !== ST_IDLE || seq_hold !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0 ||
            waddr !== '0 || wdata !== '0) begin
            errors++;
            $display("FAIL reset_abort: state=%0d hold=%b rdy=%b done=%b waddr=%0d wdata=%h, required %0d 1 0 0 0 0",
                     dbg_state, seq_hold, in_ready, done, waddr, wdata, ST_IDLE);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (we_cnt - base !== 1 || exp_q.size() !== 0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL abort_writes: writes=%0d pending=%0d state=%0d, required 1 0 %0d",
                     we_cnt - base, exp_q.size(), dbg_state, ST_IDLE);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        @(negedge clock);
        test_reset();
        test_two_words(1'b0);
        test_two_words(1'b1);
        test_zero_count();
        test_error_then_recover();
        test_full_depth_header();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ucode_loader.md
# ucode_loader

Writes microcode into the writable control store that the microsequencer fetches from; it is the write side of the store the sequencer reads. It accepts a byte stream over a valid/ready handshake, assembles 47-bit store words, and writes them to consecutive store addresses starting at 0. It holds the sequencer in reset from power-up until a load completes, so no microcode runs from a partially loaded store.

## Interface
Parameters:
- ADDR_WIDTH, 13, control-store address width; store depth is 2^ADDR_WIDTH.
- WORD_WIDTH, 47, store word width: control + next-address + select bit.
- BYTES_PER_WORD, ceil(WORD_WIDTH/8) = 6, derived; not overridden.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a load when the state is IDLE, DONE or ERROR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- we  out  1  store write strobe.
- waddr  out  ADDR_WIDTH  store write address.
- wdata  out  WORD_WIDTH  store write data.
- seq_hold  out  1  high while the sequencer must be held in reset; wired inverted to the sequencer's notReset.
- done  out  1  load completed.
- error  out  1  load rejected.

## Operation
- Stream format: 2-byte little-endian word count N, then N words. Each word is BYTES_PER_WORD bytes, little-endian. Byte k carries wdata[8k+7:8k]; bits above WORD_WIDTH-1 in the last byte are ignored.
- A byte transfers when in_valid && in_ready.
- States:
  - IDLE: start -> HDR_LO.
  - HDR_LO: on transfer, latch count[7:0] -> HDR_HI.
  - HDR_HI: on transfer, latch count[15:8], then:
    - full count == 0 -> DONE;
    - full count > 2^ADDR_WIDTH -> ERROR;
    - otherwise clear the byte counter and word address -> DATA.
  - DATA: on transfer, shift the byte into the assembly register and increment the byte counter. At byte BYTES_PER_WORD-1 -> WRITE.
  - WRITE: we=1 for exactly one cycle, with waddr = word address and wdata = assembled word.
    - If this is the last word (address == N-1) -> DONE.
    - Else increment the address, clear the byte counter -> DATA.
  - DONE, ERROR: hold until start -> HDR_LO, or until reset.
- in_ready = 1 only in HDR_LO, HDR_HI and DATA.
- seq_hold = 0 only in DONE, and 1 in every other state. After reset, the sequencer stays held until the first successful load.
- done = (state == DONE). error = (state == ERROR). Both are sticky until start or reset.
- start is ignored in HDR_LO, HDR_HI, DATA and WRITE.
- Address arithmetic is ADDR_WIDTH bits. N == 2^ADDR_WIDTH fills the whole store, ending at address 2^ADDR_WIDTH-1 with no wrap. The count register is 16 bits wide.

## Timing
- Reset values: state IDLE, in_ready 0, we 0, waddr 0, wdata 0, seq_hold 1, done 0, error 0.
- Reset has priority over start and over any transfer. Reset mid-load aborts to IDLE. Words already written stay in the store; the store is not cleared.
- The cycle after the last byte of a word is accepted, we is asserted. in_ready is 0 during that cycle, so each word costs BYTES_PER_WORD+1 cycles minimum.
- With in_valid held high, a full load takes 2 + N*(BYTES_PER_WORD+1) cycles from the first header byte.
- The cycle after the final WRITE, done=1 and seq_hold=0 (registered outputs).
- wdata and waddr are registered and stable whenever we=1. Outside WRITE they hold their last values.
- in_valid gaps are allowed anywhere; the loader waits with in_ready high.

## Structure
- Shared `include header, guarded like the other modules: state encodings, the BYTES_PER_WORD computation, and the header byte count (2).
- One natural sub-module, word_assembler: an 8-bit-in, WORD_WIDTH-out shift/assembly register with byte counter and last_byte flag.
- The FSM, address counter and count compare stay in ucode_loader.
- The writable store itself is a separate RAM module, outside this block.

## Test plan
- Reset, then idle 10 cycles -> seq_hold=1, in_ready=0, we=0, done=0, error=0 throughout.
- start; send 02 00, then word A bytes 01 02 03 04 05 06 and word B bytes FF FF FF FF FF FF, back-to-back -> two we pulses:
  - waddr 0, wdata 47'h060504030201;
  - waddr 1, wdata 47'h7FFFFFFFFFFF (bit 7 of the last byte dropped);
  - then done=1, seq_hold=0.
- Same load with in_valid toggling every other cycle -> identical writes, only later.
- start; send 00 00 -> DONE the next cycle, no we pulse.
- start; send 01 20 (N=8193) -> error=1, seq_hold=1, no we pulse. Then start with a valid one-word load -> error clears and done=1.
- Assert reset after 3 data bytes of word 1 in a 2-word load -> IDLE, seq_hold=1, exactly one prior we pulse (addr 0). start during that load, before the reset, is ignored.
